// File: rtl/sub_bytes_seq_if.sv
// Handshake and data bundle for the sequential SubBytes engine.
// The master side drives the round input and out_ready; the slave side is the engine.
interface sub_bytes_seq_if;
  logic [127:0] text_b;
  logic [127:0] text_b_round;
  logic [3:0]   round;
  logic         enbsb;
  logic         inv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] text_sb;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output text_b, text_b_round, round, enbsb, inv, in_valid, out_ready,
    input  in_ready, text_sb, out_valid, busy
  );

  modport slave (
    input  text_b, text_b_round, round, enbsb, inv, in_valid, out_ready,
    output in_ready, text_sb, out_valid, busy
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: NUM_SBOX forward/inverse S-box lanes walk the 16-byte state one slice per cycle.
// Latency 16/NUM_SBOX+1 cycles (bypass: BYPASS_LAT); result held in DONE until out_ready, no accept while busy.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [127:0] row;

  // One table row per high nibble; column 0 sits in the top byte of the row.
  always_comb begin
    row = '0;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    s = row[{~a[3:0], 3'b000} +: 8];
  end
endmodule

module sub_bytes_seq #(
  parameter int NUM_SBOX   = 4,
  parameter int BYPASS_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  sub_bytes_seq_if.slave io
);
  localparam int STEPS = 16 / NUM_SBOX;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int LW    = NUM_SBOX * 8;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end
  if (!(BYPASS_LAT == 0 || BYPASS_LAT == 1)) begin : g_bad_bypass_lat
    $error("sub_bytes_seq: BYPASS_LAT must be 0 or 1");
  end

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   data_q, data_d;
  logic [127:0]   text_sb_q;
  logic           inv_q;
  logic [127:0]   mux_in;
  logic           accept;
  logic           comb_pass;
  logic           sub_last;
  logic [CW-1:0]  lane_sel;
  logic [6:0]     base;
  logic [LW-1:0]  lane_in, lane_fwd, lane_inv;

  assign mux_in   = (io.round == 4'd0) ? io.text_b : io.text_b_round;
  assign accept   = io.in_valid & io.in_ready;
  assign sub_last = (cnt_q == CW'(STEPS));

  // The extra SUB cycle with cnt==STEPS only copies the finished state out, so clamp the slice index there.
  assign lane_sel = (cnt_q < CW'(STEPS)) ? cnt_q : '0;
  assign base     = 7'(32'(lane_sel) * LW);
  assign lane_in  = data_q[base +: LW];

  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    aes_sbox u_fwd (.a(lane_in[8*l +: 8]), .s(lane_fwd[8*l +: 8]));
    assign lane_inv[8*l +: 8] = inv_sbox(lane_in[8*l +: 8]);
  end

  always_comb begin
    data_d = data_q;
    data_d[base +: LW] = inv_q ? lane_inv : lane_fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (io.enbsb)             state_d = SUB;
        else if (BYPASS_LAT == 1) state_d = DONE;
      end
      SUB:  if (sub_last)     state_d = DONE;
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      data_q    <= '0;
      text_sb_q <= '0;
      inv_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          data_q <= mux_in;
          inv_q  <= io.inv;
          cnt_q  <= '0;
          if (!io.enbsb && BYPASS_LAT == 1) text_sb_q <= mux_in;
        end
        SUB: if (sub_last) begin
          text_sb_q <= data_q;
        end else begin
          data_q <= data_d;
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Zero-latency bypass only applies while idle and the live enbsb asks for pass-through.
  assign comb_pass = (BYPASS_LAT == 0) && (state_q == IDLE) && !io.enbsb;

  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    io.text_sb   = text_sb_q;
    case (state_q)
      IDLE: begin
        io.in_ready  = comb_pass ? io.out_ready : 1'b1;
        io.out_valid = comb_pass & io.in_valid;
        if (comb_pass) io.text_sb = mux_in;
      end
      SUB:  io.busy = 1'b1;
      DONE: begin
        io.busy      = 1'b1;
        io.out_valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: forward/inverse/bypass vectors, backpressure, reset mid-SUB, lane-count sweep.
module tb_sub_bytes_seq;
  localparam logic [127:0] FWD_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FWD_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] BYP     = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ALL63   = {16{8'h63}};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   tests, fails;

  always #5 clk = ~clk;

  sub_bytes_seq_if ifa(), ifc(), if1(), if2(), if8(), if16();

  assign {ifc.text_b, ifc.text_b_round, ifc.round, ifc.enbsb, ifc.inv, ifc.in_valid, ifc.out_ready} =
         {ifa.text_b, ifa.text_b_round, ifa.round, ifa.enbsb, ifa.inv, ifa.in_valid, ifa.out_ready};
  assign {if2.text_b, if2.text_b_round, if2.round, if2.enbsb, if2.inv, if2.in_valid, if2.out_ready} =
         {if1.text_b, if1.text_b_round, if1.round, if1.enbsb, if1.inv, if1.in_valid, if1.out_ready};
  assign {if8.text_b, if8.text_b_round, if8.round, if8.enbsb, if8.inv, if8.in_valid, if8.out_ready} =
         {if1.text_b, if1.text_b_round, if1.round, if1.enbsb, if1.inv, if1.in_valid, if1.out_ready};
  assign {if16.text_b, if16.text_b_round, if16.round, if16.enbsb, if16.inv, if16.in_valid, if16.out_ready} =
         {if1.text_b, if1.text_b_round, if1.round, if1.enbsb, if1.inv, if1.in_valid, if1.out_ready};

  sub_bytes_seq #(.NUM_SBOX(4),  .BYPASS_LAT(1)) u_a   (.clk(clk), .rst_n(rst_a), .io(ifa));
  sub_bytes_seq #(.NUM_SBOX(4),  .BYPASS_LAT(0)) u_c   (.clk(clk), .rst_n(rst_a), .io(ifc));
  sub_bytes_seq #(.NUM_SBOX(1),  .BYPASS_LAT(1)) u_s1  (.clk(clk), .rst_n(rst_b), .io(if1));
  sub_bytes_seq #(.NUM_SBOX(2),  .BYPASS_LAT(1)) u_s2  (.clk(clk), .rst_n(rst_b), .io(if2));
  sub_bytes_seq #(.NUM_SBOX(8),  .BYPASS_LAT(1)) u_s8  (.clk(clk), .rst_n(rst_b), .io(if8));
  sub_bytes_seq #(.NUM_SBOX(16), .BYPASS_LAT(1)) u_s16 (.clk(clk), .rst_n(rst_b), .io(if16));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (ifa.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, l1, l2, l8, l16;
    logic [127:0] t1, t2, t8, t16;
    tests = 0; fails = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.text_b = '0; ifa.text_b_round = '0; ifa.round = '0; ifa.enbsb = 1'b1; ifa.inv = 1'b0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    if1.text_b = '0; if1.text_b_round = '0; if1.round = '0; if1.enbsb = 1'b1; if1.inv = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_text_sb", ifa.text_sb, 0);
    rst_a = 1'b1;
    step();

    // forward, round 0
    ifa.round = 4'd0; ifa.enbsb = 1'b1; ifa.inv = 1'b0; ifa.text_b = FWD_IN; ifa.text_b_round = '1;
    ifa.in_valid = 1'b1;
    step();
    ifa.in_valid = 1'b0; ifa.text_b = '1;
    chk("fwd_busy", ifa.busy, 1);
    chk("fwd_in_ready", ifa.in_ready, 0);
    wait_a(lat);
    chk("fwd_latency", lat, 5);
    chk("fwd_text", ifa.text_sb, FWD_OUT);
    step();
    chk("fwd_release_valid", ifa.out_valid, 0);
    chk("fwd_release_ready", ifa.in_ready, 1);

    // inverse, round 3 takes text_b_round
    ifa.round = 4'd3; ifa.inv = 1'b1; ifa.text_b = '1; ifa.text_b_round = FWD_OUT; ifa.in_valid = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    wait_a(lat);
    chk("inv_latency", lat, 5);
    chk("inv_text", ifa.text_sb, FWD_IN);
    step();

    // bypass: zero-latency instance follows out_ready, registered one takes a cycle
    ifa.round = 4'd0; ifa.enbsb = 1'b0; ifa.inv = 1'b0; ifa.text_b = BYP; ifa.out_ready = 1'b0;
    #1;
    chk("byp0_ready_bp", ifc.in_ready, 0);
    chk("byp1_ready_idle", ifa.in_ready, 1);
    ifa.out_ready = 1'b1; ifa.in_valid = 1'b1;
    #1;
    chk("byp0_valid", ifc.out_valid, 1);
    chk("byp0_text", ifc.text_sb, BYP);
    chk("byp0_ready", ifc.in_ready, 1);
    step();
    ifa.in_valid = 1'b0;
    chk("byp1_valid", ifa.out_valid, 1);
    chk("byp1_text", ifa.text_sb, BYP);
    chk("byp0_idle", ifc.busy, 0);
    step();
    chk("byp1_release", ifa.out_valid, 0);

    // round above 10 still selects text_b_round
    ifa.round = 4'd12; ifa.enbsb = 1'b1; ifa.text_b = '1; ifa.text_b_round = '0; ifa.in_valid = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    wait_a(lat);
    chk("round12_text", ifa.text_sb, ALL63);
    step();

    // backpressure: result held, no accept while DONE
    ifa.round = 4'd0; ifa.text_b = FWD_IN; ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    wait_a(lat);
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 20; i++) begin
      ifa.in_valid = i[0];
      ifa.text_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("bp_text", ifa.text_sb, FWD_OUT);
      chk("bp_in_ready", ifa.in_ready, 0);
      chk("bp_out_valid", ifa.out_valid, 1);
    end
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    step();
    chk("bp_release_valid", ifa.out_valid, 0);
    chk("bp_release_ready", ifa.in_ready, 1);
    step(); step(); step();
    chk("bp_no_second", ifa.busy, 0);
    chk("bp_text_kept", ifa.text_sb, FWD_OUT);

    // lane-count sweep, all four engines accept on the same edge
    rst_b = 1'b1;
    step();
    if1.round = 4'd0; if1.enbsb = 1'b1; if1.inv = 1'b0; if1.text_b = FWD_IN; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    l1 = 0; l2 = 0; l8 = 0; l16 = 0; t1 = '0; t2 = '0; t8 = '0; t16 = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (l1 == 0 && if1.out_valid === 1'b1)   begin l1 = c;  t1 = if1.text_sb;  end
      if (l2 == 0 && if2.out_valid === 1'b1)   begin l2 = c;  t2 = if2.text_sb;  end
      if (l8 == 0 && if8.out_valid === 1'b1)   begin l8 = c;  t8 = if8.text_sb;  end
      if (l16 == 0 && if16.out_valid === 1'b1) begin l16 = c; t16 = if16.text_sb; end
    end
    chk("sweep1_latency", l1, 17);
    chk("sweep2_latency", l2, 9);
    chk("sweep8_latency", l8, 3);
    chk("sweep16_latency", l16, 2);
    chk("sweep1_text", t1, FWD_OUT);
    chk("sweep2_text", t2, FWD_OUT);
    chk("sweep8_text", t8, FWD_OUT);
    chk("sweep16_text", t16, FWD_OUT);

    // reset two cycles into SUB on the single-lane engine
    if1.text_b = BYP; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    step(); step();
    chk("mid_busy", if1.busy, 1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", if1.out_valid, 0);
    chk("mid_rst_text", if1.text_sb, 0);
    chk("mid_rst_ready", if1.in_ready, 1);
    chk("mid_rst_busy", if1.busy, 0);
    #2;
    rst_b = 1'b1;
    step();
    if1.text_b = '0; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    lat = 0;
    while (if1.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("post_rst_latency", lat, 17);
    chk("post_rst_text", if1.text_sb, ALL63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
